nibble_serial_add_ctrl: RTL and testbench
=========================================

// Module: nibble_serial_add_ctrl
// PURPOSE
//  Sequencer that adds two WIDTH-bit operands by running one shared 4-bit adder slice
//  over successive nibbles, LSB first, with a registered carry between nibbles.
//  Area-cheap wide adder for the bnb_adder datapath: a valid/ready request goes in,
//  and sum/carry come out after WIDTH/4 compute cycles.
// PARAMETERS
//  WIDTH     16   operand/sum width in bits; must be a multiple of 4 and >= 4
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       request valid
//  in_ready   out  1       block can accept a request (high only in IDLE)
//  a          in   WIDTH   operand A, sampled at accept
//  b          in   WIDTH   operand B, sampled at accept
//  c_in       in   1       carry-in, sampled at accept
//  out_valid  out  1       result valid (high only in DONE)
//  out_ready  in   1       consumer takes the result
//  sum        out  WIDTH   result bits, stable while out_valid
//  c_out      out  1       final carry out of nibble NIBBLES-1
//  busy       out  1       high in RUN or DONE
// BEHAVIOUR
//  - NIBBLES = WIDTH/4. idx counter width = $clog2(NIBBLES), minimum 1.
//  - Reset (async, rst_n=0): state=IDLE, idx=0, carry=0, sum=0, c_out=0, out_valid=0,
//    in_ready=1 after release, busy=0. Reset mid-RUN/DONE aborts the operation silently.
//  - IDLE: in_ready=1. Accept on in_valid&&in_ready at edge: latch a, b, carry<=c_in,
//    idx<=0, then go to RUN.
//  - RUN: the slice adds a[4*idx+:4], b[4*idx+:4], and carry. At each edge:
//    sum[4*idx+:4]<=slice sum, carry<=slice cout, idx<=idx+1.
//    On idx==NIBBLES-1: c_out<=slice cout, go to DONE.
//  - DONE: out_valid=1. sum/c_out hold until out_ready=1, then go to IDLE at that edge.
//  - Latency: accept at edge E gives out_valid at edge E+NIBBLES. There is no same-cycle
//    re-accept from DONE, so minimum spacing is NIBBLES+2 cycles per operation.
//  - in_valid while busy is ignored; no capture and no side effect.
//  - Arithmetic: {c_out,sum} = a + b + c_in, modulo 2^(WIDTH+1); there is no overflow flag.
//  - sum is not cleared on accept. Stale nibbles are overwritten during RUN, and
//    sum is only defined while out_valid.
//  - WIDTH==4: single RUN cycle; idx wrap is not reachable.
// CONFIGURATION
//  NSA_SUB_EN defined: adds port sub (in, 1), sampled at accept. When sub=1 the slice sees
//    ~b nibbles and the initial carry is forced to 1 (c_in is ignored), giving
//    sum = a - b mod 2^WIDTH and c_out = 1 iff a >= b (unsigned, no borrow).
//  NSA_SUB_EN undefined: no sub port; add only, and the logic is identical to sub=0.
// STRUCTURE
//  Shared package/header nsa_pkg: NSA_NIBBLE=4 and state encoding IDLE=2'd0, RUN=2'd1,
//    DONE=2'd2 (2'd3 is illegal and recovers to IDLE).
//  One sub-module: nibble_adder (pure combinational 4-bit ripple adder:
//    cin, a[3:0], b[3:0] -> s[3:0], cout), instanced once. Sequencing lives in this block.
// TESTING
//  1 Reset: hold rst_n=0 -> in_ready=0 only while in reset, out_valid=0, sum=0, c_out=0,
//    busy=0. Release -> in_ready=1.
//  2 WIDTH=16, a=16'hFFFF, b=16'h0001, c_in=0 -> after 4 cycles out_valid=1, sum=16'h0000,
//    c_out=1. Also a=16'h1234, b=16'h4321, c_in=1 -> sum=16'h5556, c_out=0.
//  3 Backpressure: out_ready=0 for 10 cycles -> sum/c_out/out_valid stable, in_ready=0.
//    Then out_ready=1 -> IDLE the next cycle.
//  4 Request while busy: pulse in_valid with new operands during RUN -> ignored, and the
//    first result is unchanged.
//  5 Async reset mid-RUN (idx=2) -> all outputs reset immediately with no out_valid.
//    The next request completes correctly.
//  6 Sweep: WIDTH=4 exhaustive 16x16x2 and WIDTH=16 with 1000 random ops vs a+b+c_in model.
//    Under NSA_SUB_EN: a=5, b=7, sub=1 -> sum=16'hFFFE, c_out=0.

Source files
------------

// File: rtl/nsa_pkg.sv
// Shared constants for the nibble-serial adder: slice width and FSM state encoding.
package nsa_pkg;

   localparam int NSA_NIBBLE = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Index counter width; a single-nibble adder still needs a 1-bit counter.
   function automatic int nsa_idx_width(input int nibbles);
      return (nibbles > 1) ? $clog2(nibbles) : 1;
   endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_nibble_adder.sv
// Combinational 4-bit ripple-carry slice shared by every nibble of the serial adder.
module nibble_adder
   import nsa_pkg::*;
(
   input  logic                  cin_i,
   input  logic [NSA_NIBBLE-1:0] a_i,
   input  logic [NSA_NIBBLE-1:0] b_i,
   output logic [NSA_NIBBLE-1:0] s_o,
   output logic                  cout_o
);

   always_comb begin
      logic [NSA_NIBBLE:0] c;
      c    = '0;
      s_o  = '0;
      c[0] = cin_i;
      for (int i = 0; i < NSA_NIBBLE; i++) begin
         s_o[i]  = a_i[i] ^ b_i[i] ^ c[i];
         c[i+1]  = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
      end
      cout_o = c[NSA_NIBBLE];
   end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Wide adder built by stepping one 4-bit slice over the operands, LSB nibble first.
// Define NSA_SUB_EN to add a sub_i port that turns the operation into a - b.
//
// state   | meaning
// IDLE    | waiting for a request, in_ready_o high
// RUN     | one nibble added per cycle, carry held in carry_q
// DONE    | result presented on out_valid_o until out_ready_i
module nibble_serial_add_ctrl
   import nsa_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             c_in_i,
`ifdef NSA_SUB_EN
   input  logic             sub_i,
`endif
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             c_out_o,
   output logic             busy_o
);

   localparam int NIBBLES = WIDTH / NSA_NIBBLE;
   localparam int IDXW    = nsa_idx_width(NIBBLES);

   logic [1:0]            state_q, state_d;
   logic [IDXW-1:0]       idx_q, idx_d;
   logic                  carry_q, carry_d;
   logic [WIDTH-1:0]      a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic                  c_out_q, c_out_d;
   logic [NSA_NIBBLE-1:0] nib_a, nib_b, slice_s;
   logic                  slice_co;
   logic                  accept, last;
   logic                  sub_acc, sub_act;

   assign in_ready_o  = (state_q == ST_IDLE) & rst_n_i;
   assign out_valid_o = (state_q == ST_DONE);
   assign busy_o      = (state_q == ST_RUN) | (state_q == ST_DONE);
   assign sum_o       = sum_q;
   assign c_out_o     = c_out_q;
   assign accept      = in_valid_i & in_ready_o;
   assign last        = (idx_q == IDXW'(NIBBLES - 1));

`ifdef NSA_SUB_EN
   logic sub_q;
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)    sub_q <= 1'b0;
      else if (accept) sub_q <= sub_i;
   end
   assign sub_acc = sub_i;
   assign sub_act = sub_q;
`else
   assign sub_acc = 1'b0;
   assign sub_act = 1'b0;
`endif

   always_comb begin
      nib_a = '0;
      nib_b = '0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (idx_q == IDXW'(i)) begin
            nib_a = a_q[i*NSA_NIBBLE +: NSA_NIBBLE];
            nib_b = b_q[i*NSA_NIBBLE +: NSA_NIBBLE];
         end
      end
   end

   // Subtraction is a + ~b + 1: invert each b nibble, the forced carry-in supplies the +1.
   nibble_adder u_slice (
      .cin_i  (carry_q),
      .a_i    (nib_a),
      .b_i    (nib_b ^ {NSA_NIBBLE{sub_act}}),
      .s_o    (slice_s),
      .cout_o (slice_co)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      c_out_d = c_out_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               a_d     = a_i;
               b_d     = b_i;
               carry_d = sub_acc | c_in_i;
               idx_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            for (int i = 0; i < NIBBLES; i++) begin
               if (idx_q == IDXW'(i)) sum_d[i*NSA_NIBBLE +: NSA_NIBBLE] = slice_s;
            end
            carry_d = slice_co;
            idx_d   = idx_q + IDXW'(1);
            if (last) begin
               idx_d   = '0;
               c_out_d = slice_co;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         c_out_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         c_out_q <= c_out_d;
      end
   end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed and swept checks of nibble_serial_add_ctrl at WIDTH=16 and WIDTH=4.
module tb_nibble_serial_add_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        in_valid, in_ready, c_in, out_valid, out_ready, c_out, busy;
   logic [15:0] a, b, sum;
   logic        in_valid4, in_ready4, c_in4, out_valid4, out_ready4, c_out4, busy4;
   logic [3:0]  a4, b4, sum4;
`ifdef NSA_SUB_EN
   logic        sub16, sub4;
`endif

   int tests = 0;
   int fails = 0;

   nibble_serial_add_ctrl #(.WIDTH(16)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .a_i(a), .b_i(b), .c_in_i(c_in),
`ifdef NSA_SUB_EN
      .sub_i(sub16),
`endif
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .sum_o(sum), .c_out_o(c_out), .busy_o(busy)
   );

   nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
      .clk_i(clk), .rst_n_i(rst_n),
      .in_valid_i(in_valid4), .in_ready_o(in_ready4),
      .a_i(a4), .b_i(b4), .c_in_i(c_in4),
`ifdef NSA_SUB_EN
      .sub_i(sub4),
`endif
      .out_valid_o(out_valid4), .out_ready_i(out_ready4),
      .sum_o(sum4), .c_out_o(c_out4), .busy_o(busy4)
   );

   task automatic accept16(input logic [15:0] av, input logic [15:0] bv, input logic ci);
      @(negedge clk);
      a = av; b = bv; c_in = ci; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid16(output int lat);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic release16();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      tests++; if (sum !== 16'h0) begin fails++; $display("FAIL reset_sum got=%h exp=0000", sum); end
      tests++; if (c_out !== 1'b0) begin fails++; $display("FAIL reset_c_out got=%b exp=0", c_out); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
      tests++; if (in_ready4 !== 1'b1) begin fails++; $display("FAIL release_in_ready4 got=%b exp=1", in_ready4); end
   endtask

   task automatic test_add();
      int lat;
      accept16(16'hFFFF, 16'h0001, 1'b0);
      wait_valid16(lat);
      tests++; if (lat !== 4) begin fails++; $display("FAIL add1_latency got=%0d exp=4", lat); end
      tests++; if (sum !== 16'h0000) begin fails++; $display("FAIL add1_sum got=%h exp=0000", sum); end
      tests++; if (c_out !== 1'b1) begin fails++; $display("FAIL add1_c_out got=%b exp=1", c_out); end
      release16();
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL add1_idle got=%b exp=1", in_ready); end
      accept16(16'h1234, 16'h4321, 1'b1);
      wait_valid16(lat);
      tests++; if (lat !== 4) begin fails++; $display("FAIL add2_latency got=%0d exp=4", lat); end
      tests++; if (sum !== 16'h5556) begin fails++; $display("FAIL add2_sum got=%h exp=5556", sum); end
      tests++; if (c_out !== 1'b0) begin fails++; $display("FAIL add2_c_out got=%b exp=0", c_out); end
      release16();
   endtask

   task automatic test_backpressure();
      int lat;
      accept16(16'h1234, 16'h4321, 1'b1);
      wait_valid16(lat);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", i, out_valid); end
         tests++; if (sum !== 16'h5556) begin fails++; $display("FAIL bp_sum cyc=%0d got=%h exp=5556", i, sum); end
         tests++; if (c_out !== 1'b0) begin fails++; $display("FAIL bp_c_out cyc=%0d got=%b exp=0", i, c_out); end
         tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
      end
      release16();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL bp_release_busy got=%b exp=0", busy); end
   endtask

   task automatic test_busy_ignore();
      int lat;
      accept16(16'h0F0F, 16'h0101, 1'b0);
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL busy_in_ready got=%b exp=0", in_ready); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL busy_flag got=%b exp=1", busy); end
      @(negedge clk);
      a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid16(lat);
      tests++; if (lat !== 3) begin fails++; $display("FAIL busy_latency got=%0d exp=3", lat); end
      tests++; if (sum !== 16'h1010) begin fails++; $display("FAIL busy_sum got=%h exp=1010", sum); end
      tests++; if (c_out !== 1'b0) begin fails++; $display("FAIL busy_c_out got=%b exp=0", c_out); end
      release16();
      repeat (6) begin @(posedge clk); #1; end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_no_side_effect got=%b exp=0", busy); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL busy_no_result got=%b exp=0", out_valid); end
   endtask

   task automatic test_reset_mid_run();
      int lat;
      accept16(16'h1111, 16'h2222, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL midrst_pre_busy got=%b exp=1", busy); end
      rst_n = 1'b0;
      #1;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      tests++; if (sum !== 16'h0) begin fails++; $display("FAIL midrst_sum got=%h exp=0000", sum); end
      tests++; if (c_out !== 1'b0) begin fails++; $display("FAIL midrst_c_out got=%b exp=0", c_out); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL midrst_in_ready got=%b exp=0", in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midrst_release got=%b exp=1", in_ready); end
      accept16(16'h1111, 16'h2222, 1'b0);
      wait_valid16(lat);
      tests++; if (lat !== 4) begin fails++; $display("FAIL midrst_next_latency got=%0d exp=4", lat); end
      tests++; if ({c_out, sum} !== 17'h03333) begin fails++; $display("FAIL midrst_next_result got=%h exp=03333", {c_out, sum}); end
      release16();
   endtask

   task automatic test_sweep4();
      int lat;
      logic [4:0] exp;
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            for (int k = 0; k < 2; k++) begin
               @(negedge clk);
               a4 = 4'(i); b4 = 4'(j); c_in4 = 1'(k); in_valid4 = 1'b1;
               @(posedge clk); #1;
               in_valid4 = 1'b0;
               lat = 0;
               while (out_valid4 !== 1'b1 && lat < 20) begin
                  @(posedge clk); #1;
                  lat++;
               end
               exp = 5'(i) + 5'(j) + 5'(k);
               tests++;
               if ({c_out4, sum4} !== exp || lat !== 1) begin
                  fails++;
                  $display("FAIL sweep4 a=%0d b=%0d c=%0d got=%h lat=%0d exp=%h lat=1", i, j, k, {c_out4, sum4}, lat, exp);
               end
               @(negedge clk);
               out_ready4 = 1'b1;
               @(posedge clk); #1;
               out_ready4 = 1'b0;
            end
         end
      end
   endtask

   task automatic test_random16();
      int lat;
      logic [15:0] av, bv;
      logic        ci;
      logic [16:0] exp;
      for (int n = 0; n < 1000; n++) begin
         av = 16'($urandom);
         bv = 16'($urandom);
         ci = 1'($urandom_range(0, 1));
         exp = {1'b0, av} + {1'b0, bv} + {16'h0, ci};
         accept16(av, bv, ci);
         wait_valid16(lat);
         tests++;
         if ({c_out, sum} !== exp || lat !== 4) begin
            fails++;
            $display("FAIL random16 a=%h b=%h c=%b got=%h lat=%0d exp=%h lat=4", av, bv, ci, {c_out, sum}, lat, exp);
         end
         release16();
      end
   endtask

`ifdef NSA_SUB_EN
   task automatic test_sub();
      int lat;
      sub16 = 1'b1;
      accept16(16'h0005, 16'h0007, 1'b1);
      wait_valid16(lat);
      tests++; if ({c_out, sum} !== 17'h0FFFE) begin fails++; $display("FAIL sub_5m7 got=%h exp=0fffe", {c_out, sum}); end
      release16();
      accept16(16'h0007, 16'h0005, 1'b0);
      wait_valid16(lat);
      tests++; if ({c_out, sum} !== 17'h10002) begin fails++; $display("FAIL sub_7m5 got=%h exp=10002", {c_out, sum}); end
      release16();
      accept16(16'h1234, 16'h1234, 1'b0);
      wait_valid16(lat);
      tests++; if ({c_out, sum} !== 17'h10000) begin fails++; $display("FAIL sub_equal got=%h exp=10000", {c_out, sum}); end
      release16();
      sub16 = 1'b0;
   endtask
`endif

   initial begin
      in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0;
      in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; c_in4 = 1'b0;
`ifdef NSA_SUB_EN
      sub16 = 1'b0; sub4 = 1'b0;
`endif
      test_reset();
      test_add();
      test_backpressure();
      test_busy_ignore();
      test_reset_mid_run();
      test_sweep4();
      test_random16();
`ifdef NSA_SUB_EN
      test_sub();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog time limit reached, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

endmodule
